operand_gatherer: RTL and testbench

Collects a stream of 16-bit words into groups of three and presents each group as stable parallel operands `var1`/`var2`/`var3` with a `trigger` pulse. It sits directly upstream of the three-cycle accumulate sequencer, which adds var1, var2 and var3 into `sum` on a rising edge of `trigger`. Double buffering lets the next group be collected while the current one is held. The trigger shape guarantees one clean rising edge per group.

---
 rtl/operand_gatherer_pkg.sv | 24 ++
 rtl/operand_gatherer.sv | 155 +++++++++++++++
 tb/tb_operand_gatherer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_gatherer_pkg.sv
// Shared types and defaults for the operand gatherer: presentation states,
// operand width, and hold/gap counter sizing.
package operand_gatherer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_e;

  localparam int WIDTH_DEF = 16;
  localparam int HOLD_DEF  = 4;
  localparam int GAP_DEF   = 1;

  // The counter only ever holds (cycles - 1), so clog2 of the larger phase suffices.
  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  localparam int CNT_W = cnt_width(HOLD_DEF, GAP_DEF);

endpackage

// File: rtl/operand_gatherer.sv
// Collects words into groups of three, double-buffers them, and presents each
// group on var1..3 with a HOLD_CYCLES-wide trigger pulse followed by a gap.
//
// state   | meaning
// IDLE    | waiting for a full staged group
// PRESENT | trigger high, operands held, counting HOLD_CYCLES
// GAP     | trigger low, counting GAP_CYCLES before returning to IDLE
module operand_gatherer
  import operand_gatherer_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int HOLD_CYCLES = HOLD_DEF,
  parameter int GAP_CYCLES  = GAP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] var1,
  output logic [WIDTH-1:0] var2,
  output logic [WIDTH-1:0] var3,
  output logic             trigger,
  output logic             busy,
  output logic [7:0]       group_count
);

  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             stg_full_q, stg_full_d;
  logic [WIDTH-1:0] stg0_q, stg0_d, stg1_q, stg1_d, stg2_q, stg2_d;
  logic [WIDTH-1:0] var1_q, var1_d, var2_q, var2_d, var3_q, var3_d;
  logic             trigger_q, trigger_d;
  logic             busy_q, busy_d;
  logic [7:0]       group_count_q, group_count_d;
  logic             accept;

  assign in_ready = reset & ~stg_full_q;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    stg_full_d    = stg_full_q;
    stg0_d        = stg0_q;
    stg1_d        = stg1_q;
    stg2_d        = stg2_q;
    var1_d        = var1_q;
    var2_d        = var2_q;
    var3_d        = var3_q;
    trigger_d     = trigger_q;
    busy_d        = busy_q;
    group_count_d = group_count_q;

    // Flush beats a same-cycle handshake: the word is consumed but dropped.
    if (flush) begin
      idx_d = 2'd0;
    end else if (accept) begin
      case (idx_q)
        2'd0:    stg0_d = in_data;
        2'd1:    stg1_d = in_data;
        default: stg2_d = in_data;
      endcase
      if (idx_q == 2'd2) begin
        idx_d      = 2'd0;
        stg_full_d = 1'b1;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (stg_full_q) begin
          var1_d        = stg0_q;
          var2_d        = stg1_q;
          var3_d        = stg2_q;
          stg_full_d    = 1'b0;
          trigger_d     = 1'b1;
          busy_d        = 1'b1;
          group_count_d = group_count_q + 8'd1;
          cnt_d         = CW'(HOLD_CYCLES - 1);
          state_d       = PRESENT;
        end
      end
      PRESENT: begin
        if (cnt_q == '0) begin
          trigger_d = 1'b0;
          cnt_d     = CW'(GAP_CYCLES - 1);
          state_d   = GAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        trigger_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= 2'd0;
      stg_full_q    <= 1'b0;
      stg0_q        <= '0;
      stg1_q        <= '0;
      stg2_q        <= '0;
      var1_q        <= '0;
      var2_q        <= '0;
      var3_q        <= '0;
      trigger_q     <= 1'b0;
      busy_q        <= 1'b0;
      group_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      stg_full_q    <= stg_full_d;
      stg0_q        <= stg0_d;
      stg1_q        <= stg1_d;
      stg2_q        <= stg2_d;
      var1_q        <= var1_d;
      var2_q        <= var2_d;
      var3_q        <= var3_d;
      trigger_q     <= trigger_d;
      busy_q        <= busy_d;
      group_count_q <= group_count_d;
    end
  end

  assign var1        = var1_q;
  assign var2        = var2_q;
  assign var3        = var3_q;
  assign trigger     = trigger_q;
  assign busy        = busy_q;
  assign group_count = group_count_q;

endmodule

// File: tb/tb_operand_gatherer.sv
// Directed bench for operand_gatherer with default parameters (hold 4, gap 1).
module tb_operand_gatherer;

  logic        clk;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [15:0] var1, var2, var3;
  logic        trigger;
  logic        busy;
  logic [7:0]  group_count;

  int vectors;
  int miscompares;
  int rises;
  logic trig_prev;

  operand_gatherer dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .var1        (var1),
    .var2        (var2),
    .var3        (var3),
    .trigger     (trigger),
    .busy        (busy),
    .group_count (group_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rises     = 0;
    trig_prev = 1'b0;
  end

  always @(negedge clk) begin
    if (trigger === 1'b1 && trig_prev === 1'b0) rises = rises + 1;
    trig_prev = trigger;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp)
    else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    in_valid = 1'b1;
    in_data  = a;
    step();
    in_data = b;
    step();
    in_data = c;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int word_ptr;
    int rise_base;
    logic acc;
    logic [15:0] stream [6];

    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 16'h0;
    flush       = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_trigger", 32'(trigger), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_var1", 32'(var1), 32'd0);
    chk("rst_gc", 32'(group_count), 32'd0);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Group 1,2,3: trigger one cycle after third handshake, high 4 cycles
    send3(16'h0001, 16'h0002, 16'h0003);
    chk("t1_full_ready", 32'(in_ready), 32'd0);
    chk("t1_no_trig_yet", 32'(trigger), 32'd0);
    step();
    chk("t1_trig_rise", 32'(trigger), 32'd1);
    chk("t1_var1", 32'(var1), 32'h1);
    chk("t1_var2", 32'(var2), 32'h2);
    chk("t1_var3", 32'(var3), 32'h3);
    chk("t1_gc", 32'(group_count), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready_back", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_trig_hold", 32'(trigger), 32'd1);
    end
    step();
    chk("t1_trig_fall", 32'(trigger), 32'd0);
    chk("t1_busy_gap", 32'(busy), 32'd1);
    step();
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // Continuous stream 0x10..0x15
    for (int i = 0; i < 6; i++) stream[i] = 16'h0010 + 16'(i);
    word_ptr = 0;
    in_valid = 1'b1;
    in_data  = stream[0];
    for (int c = 1; c <= 10; c++) begin
      acc = in_valid & in_ready;
      step();
      if (acc) begin
        word_ptr = word_ptr + 1;
        if (word_ptr >= 6) in_valid = 1'b0;
        else in_data = stream[word_ptr];
      end
      case (c)
        3: chk("t2_ready_full", 32'(in_ready), 32'd0);
        4: begin
          chk("t2_g1_trig", 32'(trigger), 32'd1);
          chk("t2_g1_var1", 32'(var1), 32'h10);
          chk("t2_g1_var3", 32'(var3), 32'h12);
        end
        5, 6: begin
          chk("t2_hold_var1", 32'(var1), 32'h10);
          chk("t2_hold_var2", 32'(var2), 32'h11);
        end
        7: begin
          chk("t2_hold_var3", 32'(var3), 32'h12);
          chk("t2_stall_ready", 32'(in_ready), 32'd0);
        end
        8: chk("t2_trig_low", 32'(trigger), 32'd0);
        9: begin
          chk("t2_gap_trig", 32'(trigger), 32'd0);
          chk("t2_gap_var3", 32'(var3), 32'h12);
        end
        10: begin
          chk("t2_g2_trig", 32'(trigger), 32'd1);
          chk("t2_g2_var1", 32'(var1), 32'h13);
          chk("t2_g2_var2", 32'(var2), 32'h14);
          chk("t2_g2_var3", 32'(var3), 32'h15);
          chk("t2_gc", 32'(group_count), 32'd3);
        end
        default: ;
      endcase
    end
    in_valid = 1'b0;
    repeat (6) step();
    chk("t2_idle", 32'(busy), 32'd0);

    // Partial group then flush
    in_valid = 1'b1;
    in_data  = 16'hAAAA;
    step();
    in_data = 16'hBBBB;
    step();
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk("t3_no_trig", 32'(trigger), 32'd0);
    chk("t3_not_busy", 32'(busy), 32'd0);
    send3(16'h0001, 16'h0002, 16'h0003);
    step();
    chk("t3_trig", 32'(trigger), 32'd1);
    chk("t3_var1", 32'(var1), 32'h1);
    chk("t3_var2", 32'(var2), 32'h2);
    chk("t3_var3", 32'(var3), 32'h3);
    chk("t3_gc", 32'(group_count), 32'd4);
    repeat (6) step();

    // Flush coincident with third handshake
    in_valid = 1'b1;
    in_data  = 16'h0007;
    step();
    in_data = 16'h0008;
    step();
    in_data = 16'h0009;
    flush   = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("t4_ready", 32'(in_ready), 32'd1);
    step();
    chk("t4_no_trig", 32'(trigger), 32'd0);
    step();
    chk("t4_no_trig2", 32'(trigger), 32'd0);
    chk("t4_gc", 32'(group_count), 32'd4);
    send3(16'h0021, 16'h0022, 16'h0023);
    step();
    chk("t4_idx0_var1", 32'(var1), 32'h21);
    chk("t4_idx0_var3", 32'(var3), 32'h23);
    chk("t4_gc2", 32'(group_count), 32'd5);
    repeat (6) step();

    // Reset during PRESENT
    send3(16'h0031, 16'h0032, 16'h0033);
    step();
    chk("t5_trig", 32'(trigger), 32'd1);
    step();
    reset = 1'b0;
    step();
    chk("t5_trig0", 32'(trigger), 32'd0);
    chk("t5_var1", 32'(var1), 32'd0);
    chk("t5_var2", 32'(var2), 32'd0);
    chk("t5_var3", 32'(var3), 32'd0);
    chk("t5_gc", 32'(group_count), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    #1;
    chk("t5_ready", 32'(in_ready), 32'd1);
    step();
    chk("t5_no_trig", 32'(trigger), 32'd0);

    // 256 groups: counter wrap, one rising edge per group
    rise_base = rises;
    for (int g = 1; g <= 256; g++) begin
      send3(16'(g), 16'(g + 1), 16'(g + 2));
      step();
      if (g == 255) chk("t6_gc255", 32'(group_count), 32'd255);
      if (g == 100) chk("t6_var2", 32'(var2), 32'd101);
      repeat (5) step();
    end
    step();
    chk("t6_gc_wrap", 32'(group_count), 32'd0);
    chk("t6_rises", 32'(rises - rise_base), 32'd256);
    chk("t6_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
